// File: rtl/a2d_pkg.sv
// Shared types for the A2D round-robin sampler: top FSM states, channel
// rotation pointer and the fixed padding of the A2D command word.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

    typedef enum logic [1:0] {LFT, RGHT, BATT} chan_t;

    localparam logic [10:0] A2D_CMD_PAD = 11'h000;

    function automatic chan_t next_chan(input chan_t c);
        case (c)
            LFT:     return RGHT;
            RGHT:    return BATT;
            default: return LFT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_sampler_spi.sv
// 16-bit mode-3 SPI master, MSB first. SCLK is the MSB of a free-running
// divider that idles at the preload value, so SCLK rests high.
module spi_mnrch #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    localparam logic [SCLK_DIV_W-1:0] DIV_PRE  = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;
    localparam logic [SCLK_DIV_W-1:0] DIV_SMPL = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

    logic                  busy_q;
    logic [SCLK_DIV_W-1:0] div_q;
    logic [4:0]            smpl_cnt_q;
    logic [15:0]           tx_q;
    logic [15:0]           rx_q;
    logic                  ss_n_q;
    logic                  done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            div_q      <= DIV_PRE;
            smpl_cnt_q <= 5'd0;
            tx_q       <= 16'h0000;
            rx_q       <= 16'h0000;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                // Counting starts on the start edge so the first fall lands 8 clk after SS_n falls
                if (wrt) begin
                    busy_q     <= 1'b1;
                    ss_n_q     <= 1'b0;
                    div_q      <= div_q + 1'b1;
                    smpl_cnt_q <= 5'd0;
                    tx_q       <= wt_data;
                end
            end else begin
                div_q <= div_q + 1'b1;
                if (div_q == DIV_SMPL) begin
                    rx_q       <= {rx_q[14:0], MISO};
                    smpl_cnt_q <= smpl_cnt_q + 5'd1;
                end
                if (div_q == DIV_FALL) begin
                    // First fall only opens the frame: bit 15 is already on MOSI
                    if (smpl_cnt_q == 5'd16) begin
                        busy_q <= 1'b0;
                        ss_n_q <= 1'b1;
                        done_q <= 1'b1;
                        div_q  <= DIV_PRE;
                    end else if (smpl_cnt_q != 5'd0) begin
                        tx_q <= {tx_q[14:0], 1'b0};
                    end
                end
            end
        end
    end

    assign done    = done_q;
    assign rd_data = rx_q;
    assign SS_n    = ss_n_q;
    assign SCLK    = div_q[SCLK_DIV_W-1];
    assign MOSI    = tx_q[15];

endmodule

// File: rtl/a2d_sampler.sv
// Round-robin sampler for left/right load cells and battery. Each nxt runs
// two A2D transactions; only the second response carries the wanted channel.
module a2d_sampler
    import a2d_pkg::*;
#(
    parameter int         SCLK_DIV_W = 5,
    parameter logic [2:0] CH_LFT     = 3'd0,
    parameter logic [2:0] CH_RGHT    = 3'd4,
    parameter logic [2:0] CH_BATT    = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        A2D_SS_n,
    output logic        A2D_SCLK,
    output logic        A2D_MOSI,
    input  logic        A2D_MISO
);

    state_t      state_q, state_d;
    chan_t       ptr_q, ptr_d;
    logic [11:0] lft_q, rght_q, batt_q;
    logic        cmplt_q;
    logic        wrt, ld;
    logic        spi_done;
    logic [15:0] rd_data;
    logic [2:0]  cur_ch;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        case (ptr_q)
            RGHT:    cur_ch = CH_RGHT;
            BATT:    cur_ch = CH_BATT;
            default: cur_ch = CH_LFT;
        endcase
    end

    spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data ({2'b00, cur_ch, A2D_CMD_PAD}),
        .MISO    (A2D_MISO),
        .done    (spi_done),
        .rd_data (rd_data),
        .SS_n    (A2D_SS_n),
        .SCLK    (A2D_SCLK),
        .MOSI    (A2D_MOSI)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrt     = 1'b0;
        ld      = 1'b0;
        case (state_q)
            IDLE: if (nxt) begin
                wrt     = 1'b1;
                state_d = XFER1;
            end
            // Restart in the done cycle so SS_n stays high for exactly one clk
            XFER1: if (spi_done) begin
                wrt     = 1'b1;
                state_d = GAP;
            end
            GAP: state_d = XFER2;
            XFER2: if (spi_done) begin
                ld      = 1'b1;
                ptr_d   = next_chan(ptr_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= LFT;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
            cmplt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cmplt_q <= ld;
            if (ld) begin
                case (ptr_q)
                    RGHT:    rght_q <= rd_data[11:0];
                    BATT:    batt_q <= rd_data[11:0];
                    default: lft_q  <= rd_data[11:0];
                endcase
            end
        end
    end

    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_a2d_sampler.sv
// Bench for a2d_sampler: behavioural ADC128S-style slave plus a scoreboard of
// expected output triples pushed at each accepted nxt.
module tb_a2d_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt;
    logic        A2D_SS_n, A2D_SCLK, A2D_MOSI, A2D_MISO;

    a2d_sampler dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .A2D_SS_n  (A2D_SS_n),
        .A2D_SCLK  (A2D_SCLK),
        .A2D_MOSI  (A2D_MOSI),
        .A2D_MISO  (A2D_MISO)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] lft_v  = 12'h250;
    logic [11:0] rght_v = 12'h201;
    logic [11:0] batt_v = 12'h810;

    typedef struct packed {
        logic [11:0] l;
        logic [11:0] r;
        logic [11:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t model   = '0;
    int   exp_ptr = 0;
    exp_t e;

    function automatic void push_exp();
        case (exp_ptr)
            0:       model.l = lft_v;
            1:       model.r = rght_v;
            default: model.b = batt_v;
        endcase
        sb.push_back(model);
        exp_ptr = (exp_ptr + 1) % 3;
    endfunction

    // ---------------- ADC model ----------------
    logic        ss_p = 1'b1, sc_p = 1'b1;
    logic [15:0] adc_sh = 16'h0000;
    logic [15:0] cmd = 16'h0000;
    int          nfall = 0, nrise = 0;
    logic [2:0]  prev_ch = 3'd0;
    logic [15:0] frames[$];

    assign A2D_MISO = adc_sh[15];

    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        if (ch == 3'd0) return lft_v;
        if (ch == 3'd4) return rght_v;
        if (ch == 3'd5) return batt_v;
        return 12'hfff;
    endfunction

    always @(negedge clk) begin
        ss_p <= A2D_SS_n;
        sc_p <= A2D_SCLK;
        if (ss_p === 1'b1 && A2D_SS_n === 1'b0) begin
            // Converter answers with the channel requested in the previous frame
            adc_sh <= {4'h0, adc_val(prev_ch)};
            nfall  <= 0;
            nrise  <= 0;
            cmd    <= 16'h0000;
        end else if (A2D_SS_n === 1'b0) begin
            if (sc_p && !A2D_SCLK) begin
                if (nfall != 0) adc_sh <= {adc_sh[14:0], 1'b0};
                nfall <= nfall + 1;
            end
            if (!sc_p && A2D_SCLK) begin
                cmd   <= {cmd[14:0], A2D_MOSI};
                nrise <= nrise + 1;
            end
        end
        if (ss_p === 1'b0 && A2D_SS_n === 1'b1 && nrise == 16) begin
            prev_ch <= cmd[13:11];
            frames.push_back(cmd);
        end
    end

    // ---------------- helpers (no comparisons) ----------------
    task automatic pulse_nxt();
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
    endtask

    task automatic wait_cmplt(input int max, output int lat);
        lat = 1;
        while (lat < max) begin
            @(negedge clk);
            lat++;
            if (cnv_cmplt === 1'b1) return;
        end
        lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n_cmp = 0, n_ss = 0, n_sc = 0, n_nz = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (lft_ld !== 12'h000) begin n_err++; $display("FAIL rst_lft got %h want 000", lft_ld); end
        n_vec++; if (rght_ld !== 12'h000) begin n_err++; $display("FAIL rst_rght got %h want 000", rght_ld); end
        n_vec++; if (batt !== 12'h000) begin n_err++; $display("FAIL rst_batt got %h want 000", batt); end
        n_vec++; if (cnv_cmplt !== 1'b0) begin n_err++; $display("FAIL rst_cmplt got %b want 0", cnv_cmplt); end
        n_vec++; if (A2D_SS_n !== 1'b1) begin n_err++; $display("FAIL rst_ss_n got %b want 1", A2D_SS_n); end
        n_vec++; if (A2D_SCLK !== 1'b1) begin n_err++; $display("FAIL rst_sclk got %b want 1", A2D_SCLK); end
        n_vec++; if (A2D_MOSI !== 1'b0) begin n_err++; $display("FAIL rst_mosi got %b want 0", A2D_MOSI); end
        rst = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (cnv_cmplt !== 1'b0) n_cmp++;
            if (A2D_SS_n !== 1'b1) n_ss++;
            if (A2D_SCLK !== 1'b1) n_sc++;
            if ({lft_ld, rght_ld, batt} !== 36'h0) n_nz++;
        end
        n_vec++; if (n_cmp != 0) begin n_err++; $display("FAIL idle_cmplt got %0d pulses want 0", n_cmp); end
        n_vec++; if (n_ss != 0) begin n_err++; $display("FAIL idle_ss_n got %0d low cycles want 0", n_ss); end
        n_vec++; if (n_sc != 0) begin n_err++; $display("FAIL idle_sclk got %0d low cycles want 0", n_sc); end
        n_vec++; if (n_nz != 0) begin n_err++; $display("FAIL idle_outputs got %0d nonzero cycles want 0", n_nz); end
    endtask

    task automatic test_rotation();
        int lat;
        for (int i = 0; i < 3; i++) begin
            push_exp();
            pulse_nxt();
            wait_cmplt(1100, lat);
            n_vec++;
            if (lat < 1040 || lat > 1050) begin n_err++; $display("FAIL rot%0d_latency got %0d want 1040..1050", i, lat); end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({lft_ld, rght_ld, batt} !== {e.l, e.r, e.b}) begin
                    n_err++;
                    $display("FAIL rot%0d_data got %h/%h/%h want %h/%h/%h", i, lft_ld, rght_ld, batt, e.l, e.r, e.b);
                end
            end
            @(negedge clk);
            n_vec++; if (cnv_cmplt !== 1'b0) begin n_err++; $display("FAIL rot%0d_pulse_width got %b want 0", i, cnv_cmplt); end
            repeat (50) @(negedge clk);
        end
    endtask

    task automatic test_framing();
        int f1 = -1, r1 = -1, f2 = -1, r2 = -1, sf = -1, got = 0;
        logic sp = 1'b1, scp = 1'b1;
        frames.delete();
        push_exp();
        @(negedge clk); nxt = 1'b1;
        for (int t = 1; t < 1200; t++) begin
            @(negedge clk);
            nxt = 1'b0;
            if (sp && !A2D_SS_n) begin if (f1 < 0) f1 = t; else if (f2 < 0) f2 = t; end
            if (!sp && A2D_SS_n) begin if (r1 < 0) r1 = t; else if (r2 < 0) r2 = t; end
            if (scp && !A2D_SCLK && f1 >= 0 && sf < 0) sf = t;
            if (cnv_cmplt === 1'b1) begin
                got++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_vec++;
                    if ({lft_ld, rght_ld, batt} !== {e.l, e.r, e.b}) begin
                        n_err++;
                        $display("FAIL frm_data got %h/%h/%h want %h/%h/%h", lft_ld, rght_ld, batt, e.l, e.r, e.b);
                    end
                end
            end
            sp = A2D_SS_n; scp = A2D_SCLK;
        end
        n_vec++; if (r1 - f1 < 519 || r1 - f1 > 521) begin n_err++; $display("FAIL frm_ss1_len got %0d want 520+-1", r1 - f1); end
        n_vec++; if (f2 - r1 != 1) begin n_err++; $display("FAIL frm_gap got %0d want 1", f2 - r1); end
        n_vec++; if (r2 - f2 < 519 || r2 - f2 > 521) begin n_err++; $display("FAIL frm_ss2_len got %0d want 520+-1", r2 - f2); end
        n_vec++; if (sf - f1 != 8) begin n_err++; $display("FAIL frm_first_fall got %0d want 8", sf - f1); end
        n_vec++; if (got != 1) begin n_err++; $display("FAIL frm_cmplt_count got %0d want 1", got); end
        n_vec++;
        if (frames.size() != 2) begin
            n_err++; $display("FAIL frm_count got %0d want 2", frames.size());
        end else if (frames[0] !== 16'h0000 || frames[1] !== 16'h0000) begin
            n_err++; $display("FAIL frm_mosi got %h,%h want 0000,0000", frames[0], frames[1]);
        end
    endtask

    task automatic test_drop();
        int ncmp = 0, nacc = 0, t0 = 0;
        bit busy = 0;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) begin
                ncmp++;
                n_vec++;
                if (!busy || cyc - t0 < 1040 || cyc - t0 > 1050) begin
                    n_err++; $display("FAIL drop_latency got %0d want 1040..1050", cyc - t0);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_vec++;
                    if ({lft_ld, rght_ld, batt} !== {e.l, e.r, e.b}) begin
                        n_err++;
                        $display("FAIL drop_data got %h/%h/%h want %h/%h/%h", lft_ld, rght_ld, batt, e.l, e.r, e.b);
                    end
                end
                busy = 0;
            end
            nxt = (cyc < 3000) && (cyc % 100 == 0);
            if (nxt && !busy) begin busy = 1; t0 = cyc; nacc++; push_exp(); end
        end
        nxt = 1'b0;
        n_vec++; if (ncmp != 3) begin n_err++; $display("FAIL drop_cmplt_count got %0d want 3", ncmp); end
    endtask

    task automatic test_reset_mid();
        int lat, n_cmp = 0;
        push_exp();
        pulse_nxt();
        wait_cmplt(1100, lat);
        n_vec++; if (lat < 1040 || lat > 1050) begin n_err++; $display("FAIL rm_pre_latency got %0d want 1040..1050", lat); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if ({lft_ld, rght_ld, batt} !== {e.l, e.r, e.b}) begin
                n_err++; $display("FAIL rm_pre_data got %h/%h/%h want %h/%h/%h", lft_ld, rght_ld, batt, e.l, e.r, e.b);
            end
        end
        repeat (20) @(negedge clk);
        pulse_nxt();
        repeat (700) @(negedge clk);
        n_vec++; if (A2D_SS_n !== 1'b0) begin n_err++; $display("FAIL rm_in_xfer2 got ss_n=%b want 0", A2D_SS_n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (A2D_SS_n !== 1'b1) begin n_err++; $display("FAIL rm_ss_n got %b want 1", A2D_SS_n); end
        n_vec++; if (A2D_SCLK !== 1'b1) begin n_err++; $display("FAIL rm_sclk got %b want 1", A2D_SCLK); end
        n_vec++; if (A2D_MOSI !== 1'b0) begin n_err++; $display("FAIL rm_mosi got %b want 0", A2D_MOSI); end
        n_vec++; if ({lft_ld, rght_ld, batt} !== 36'h0) begin n_err++; $display("FAIL rm_outputs got %h/%h/%h want 000/000/000", lft_ld, rght_ld, batt); end
        model = '0; exp_ptr = 0; sb.delete();
        repeat (1200) begin @(negedge clk); if (cnv_cmplt !== 1'b0) n_cmp++; end
        n_vec++; if (n_cmp != 0) begin n_err++; $display("FAIL rm_no_cmplt got %0d want 0", n_cmp); end
        n_vec++; if (batt !== 12'h000) begin n_err++; $display("FAIL rm_batt_kept got %h want 000", batt); end
        push_exp();
        pulse_nxt();
        wait_cmplt(1100, lat);
        n_vec++; if (lat < 1040 || lat > 1050) begin n_err++; $display("FAIL rm_post_latency got %0d want 1040..1050", lat); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if ({lft_ld, rght_ld, batt} !== {e.l, e.r, e.b}) begin
                n_err++; $display("FAIL rm_post_data got %h/%h/%h want %h/%h/%h", lft_ld, rght_ld, batt, e.l, e.r, e.b);
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_batt_step();
        int lat;
        batt_v = 12'h755;
        for (int i = 0; i < 2; i++) begin
            push_exp();
            pulse_nxt();
            wait_cmplt(1100, lat);
            n_vec++; if (lat < 1040 || lat > 1050) begin n_err++; $display("FAIL step%0d_latency got %0d want 1040..1050", i, lat); end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if ({lft_ld, rght_ld, batt} !== {e.l, e.r, e.b}) begin
                    n_err++; $display("FAIL step%0d_data got %h/%h/%h want %h/%h/%h", i, lft_ld, rght_ld, batt, e.l, e.r, e.b);
                end
            end
            repeat (20) @(negedge clk);
        end
        n_vec++; if (batt !== 12'h755) begin n_err++; $display("FAIL step_batt got %h want 755", batt); end
        n_vec++; if (lft_ld !== 12'h250 || rght_ld !== 12'h201) begin
            n_err++; $display("FAIL step_unchanged got %h/%h want 250/201", lft_ld, rght_ld);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_framing();
        test_drop();
        test_reset_mid();
        test_batt_step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
